// File: rtl/sram_req_arbiter.sv
// sram_req_arbiter
//   Shares one SRAM-like memory port between the instruction-fetch master
//   (M0, read only) and the load/store master (M1).
//   - Address phase: M1 has fixed priority. A grant that is not accepted
//     downstream in the same cycle is locked until the handshake happens or
//     the granted master withdraws its request.
//   - Every accepted request pushes its owner (0=M0, 1=M1) into an in-order
//     FIFO. Each response beat pops the head and is steered to that owner.
//   - addr_ok and data_ok are combinational pass-throughs, so neither phase
//     gains any latency.
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   inst_*                 M0 SRAM-like port (req/size/addr in, addr_ok/data_ok/rdata out)
//   data_*                 M1 SRAM-like port (req/wr/size/wstrb/addr/wdata in, addr_ok/data_ok/rdata out)
//   mem_*                  downstream port (granted request out, addr_ok/data_ok/rdata in)
//   outstanding            accepted-but-unanswered request count
//   resp_err               sticky flag: response beat arrived with nothing outstanding
module sram_req_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     inst_req,
  input  logic [1:0]               inst_size,
  input  logic [31:0]              inst_addr,
  output logic                     inst_addr_ok,
  output logic                     inst_data_ok,
  output logic [31:0]              inst_rdata,
  input  logic                     data_req,
  input  logic                     data_wr,
  input  logic [1:0]               data_size,
  input  logic [3:0]               data_wstrb,
  input  logic [31:0]              data_addr,
  input  logic [31:0]              data_wdata,
  output logic                     data_addr_ok,
  output logic                     data_data_ok,
  output logic [31:0]              data_rdata,
  output logic                     mem_req,
  output logic                     mem_wr,
  output logic [1:0]               mem_size,
  output logic [3:0]               mem_wstrb,
  output logic [31:0]              mem_addr,
  output logic [31:0]              mem_wdata,
  input  logic                     mem_addr_ok,
  input  logic                     mem_data_ok,
  input  logic [31:0]              mem_rdata,
  output logic [$clog2(DEPTH):0]   outstanding,
  output logic                     resp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_I = 2'd1,
    LOCK_D = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic            gnt_data_s;   // 1: M1 owns the address phase, 0: M0
  logic            gnt_req_s;    // request of the granted master
  logic            full_s;
  logic            empty_s;
  logic            hs_s;         // address handshake this cycle
  logic            pop_s;        // response beat consumes the FIFO head
  logic            head_s;
  logic [DEPTH-1:0] owner_r;
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic            resp_err_r;

  // Grant selection: locked states pin the grant, IDLE picks M1 first.
  always_comb begin
    gnt_data_s = 1'b0;
    gnt_req_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (data_req) begin
          gnt_data_s = 1'b1;
          gnt_req_s  = 1'b1;
        end else begin
          gnt_data_s = 1'b0;
          gnt_req_s  = inst_req;
        end
      end
      LOCK_I: begin
        gnt_data_s = 1'b0;
        gnt_req_s  = inst_req;
      end
      LOCK_D: begin
        gnt_data_s = 1'b1;
        gnt_req_s  = data_req;
      end
      default: begin
        gnt_data_s = 1'b0;
        gnt_req_s  = 1'b0;
      end
    endcase
  end

  // full is based on the registered count only, so a same-cycle pop never
  // creates a mem_data_ok -> mem_req combinational path.
  assign full_s  = (count_r == CW'(DEPTH));
  assign empty_s = (count_r == {CW{1'b0}});
  assign mem_req = gnt_req_s & ~full_s;
  assign hs_s    = mem_req & mem_addr_ok;
  assign pop_s   = mem_data_ok & ~empty_s;
  assign head_s  = owner_r[rd_ptr_r];

  assign inst_addr_ok = hs_s & ~gnt_data_s;
  assign data_addr_ok = hs_s & gnt_data_s;
  assign inst_data_ok = pop_s & ~head_s;
  assign data_data_ok = pop_s & head_s;
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;
  assign outstanding  = count_r;
  assign resp_err     = resp_err_r;

  // Next-state: lock an unaccepted grant, release on handshake or withdrawal.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (gnt_req_s && !hs_s) begin
          state_nxt_s = gnt_data_s ? LOCK_D : LOCK_I;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOCK_I, LOCK_D: begin
        if (hs_s || !gnt_req_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Downstream request fields; an M0 grant is always a plain read.
  always_comb begin
    mem_wr    = 1'b0;
    mem_size  = 2'b00;
    mem_wstrb = 4'b0000;
    mem_addr  = 32'h0000_0000;
    mem_wdata = 32'h0000_0000;
    if (gnt_data_s) begin
      mem_wr    = data_wr;
      mem_size  = data_size;
      mem_wstrb = data_wstrb;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
    end else begin
      mem_size  = inst_size;
      mem_addr  = inst_addr;
    end
  end

  // Grant FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Owner FIFO storage; contents are don't-care while count is zero.
  always_ff @(posedge clk) begin
    if (hs_s) begin
      owner_r[wr_ptr_r] <= gnt_data_s;
    end
  end

  // FIFO pointers, occupancy count and sticky response-error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {CW{1'b0}};
      resp_err_r <= 1'b0;
    end else begin
      if (hs_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      case ({hs_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
      if (mem_data_ok && empty_s) begin
        resp_err_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Self-checking bench for sram_req_arbiter. Inputs change on the falling
// edge; outputs are sampled 1ns later, well away from the rising edge.
// Expected response owners are queued when a request is expected to be
// accepted and popped when the bench returns a response beat.
module tb_sram_req_arbiter;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        inst_req;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;
  logic [2:0]  outstanding;
  logic        resp_err;

  int total = 0;
  int bad   = 0;
  logic exp_q[$];

  sram_req_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .outstanding(outstanding), .resp_err(resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    inst_req = 1'b0; inst_size = 2'd2; inst_addr = 32'h0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd2; data_wstrb = 4'h0;
    data_addr = 32'h0; data_wdata = 32'h0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'h0;
  endtask

  // Return one response per queued owner, then expect an empty FIFO.
  task automatic drain(input string tag);
    logic        o;
    logic [31:0] rd;
    while (exp_q.size() > 0) begin
      @(negedge clk); clear_inputs();
      rd = $urandom(); mem_data_ok = 1'b1; mem_rdata = rd;
      o = exp_q.pop_front();
      #1;
      total++; if (inst_data_ok !== ~o) begin bad++; $display("FAIL %s inst_data_ok: got %b want %b", tag, inst_data_ok, ~o); end
      total++; if (data_data_ok !== o) begin bad++; $display("FAIL %s data_data_ok: got %b want %b", tag, data_data_ok, o); end
      total++; if ((o ? data_rdata : inst_rdata) !== rd) begin bad++; $display("FAIL %s rdata: got %h want %h", tag, (o ? data_rdata : inst_rdata), rd); end
    end
    @(negedge clk); clear_inputs(); #1;
    total++; if (outstanding !== 3'd0) begin bad++; $display("FAIL %s drained outstanding: got %0d want 0", tag, outstanding); end
  endtask

  task automatic test_reset();
    reset = 1'b1; clear_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b0; #1;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset mem_req: got %b want 0", mem_req); end
    total++; if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 4'b0000) begin bad++; $display("FAIL reset oks: got %b want 0000", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}); end
    total++; if (outstanding !== 3'd0) begin bad++; $display("FAIL reset outstanding: got %0d want 0", outstanding); end
    total++; if (resp_err !== 1'b0) begin bad++; $display("FAIL reset resp_err: got %b want 0", resp_err); end
  endtask

  task automatic test_single_read();
    @(negedge clk); clear_inputs();
    inst_req = 1'b1; inst_addr = 32'h1C00_0000; mem_addr_ok = 1'b1; #1;
    total++; if (inst_addr_ok !== 1'b1) begin bad++; $display("FAIL single inst_addr_ok: got %b want 1", inst_addr_ok); end
    total++; if (mem_addr !== 32'h1C00_0000) begin bad++; $display("FAIL single mem_addr: got %h want 1c000000", mem_addr); end
    total++; if (mem_wr !== 1'b0) begin bad++; $display("FAIL single mem_wr: got %b want 0", mem_wr); end
    exp_q.push_back(1'b0);
    @(negedge clk); clear_inputs(); #1;
    total++; if (outstanding !== 3'd1) begin bad++; $display("FAIL single outstanding: got %0d want 1", outstanding); end
    total++; if (data_data_ok !== 1'b0) begin bad++; $display("FAIL single idle data_data_ok: got %b want 0", data_data_ok); end
    drain("single");
  endtask

  task automatic test_priority();
    @(negedge clk); clear_inputs();
    inst_req = 1'b1; inst_addr = 32'h0000_2000;
    data_req = 1'b1; data_addr = 32'h0000_1000; mem_addr_ok = 1'b1; #1;
    total++; if ({data_addr_ok, inst_addr_ok} !== 2'b10) begin bad++; $display("FAIL prio first grant {d,i}: got %b want 10", {data_addr_ok, inst_addr_ok}); end
    total++; if (mem_addr !== 32'h0000_1000) begin bad++; $display("FAIL prio first addr: got %h want 00001000", mem_addr); end
    exp_q.push_back(1'b1);
    @(negedge clk); data_req = 1'b0; #1;
    total++; if ({data_addr_ok, inst_addr_ok} !== 2'b01) begin bad++; $display("FAIL prio second grant {d,i}: got %b want 01", {data_addr_ok, inst_addr_ok}); end
    total++; if (mem_addr !== 32'h0000_2000) begin bad++; $display("FAIL prio second addr: got %h want 00002000", mem_addr); end
    exp_q.push_back(1'b0);
    drain("prio");
  endtask

  task automatic test_lock();
    @(negedge clk); clear_inputs();
    inst_req = 1'b1; inst_addr = 32'h0000_3000; #1;
    total++; if (mem_req !== 1'b1 || inst_addr_ok !== 1'b0) begin bad++; $display("FAIL lock c0 req/ok: got %b%b want 10", mem_req, inst_addr_ok); end
    for (int c = 1; c < 3; c++) begin
      @(negedge clk);
      data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'hF; data_addr = 32'h0000_4000; data_wdata = 32'hDEAD_BEEF; #1;
      total++; if (mem_addr !== 32'h0000_3000) begin bad++; $display("FAIL lock c%0d mem_addr: got %h want 00003000", c, mem_addr); end
      total++; if ({mem_wr, mem_wstrb, data_addr_ok} !== 6'b0) begin bad++; $display("FAIL lock c%0d wr/wstrb/d_ok: got %b want 000000", c, {mem_wr, mem_wstrb, data_addr_ok}); end
      total++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL lock c%0d mem_wdata: got %h want 0", c, mem_wdata); end
    end
    @(negedge clk); mem_addr_ok = 1'b1; #1;
    total++; if ({inst_addr_ok, data_addr_ok} !== 2'b10 || mem_addr !== 32'h0000_3000) begin bad++; $display("FAIL lock release: got ok=%b addr=%h want ok=10 addr=00003000", {inst_addr_ok, data_addr_ok}, mem_addr); end
    exp_q.push_back(1'b0);
    @(negedge clk); inst_req = 1'b0; #1;
    total++; if (data_addr_ok !== 1'b1 || mem_addr !== 32'h0000_4000) begin bad++; $display("FAIL lock m1 after: got ok=%b addr=%h want ok=1 addr=00004000", data_addr_ok, mem_addr); end
    total++; if (mem_wr !== 1'b1 || mem_wdata !== 32'hDEAD_BEEF || mem_wstrb !== 4'hF) begin bad++; $display("FAIL lock m1 fields: got wr=%b wd=%h st=%h want 1/deadbeef/f", mem_wr, mem_wdata, mem_wstrb); end
    exp_q.push_back(1'b1);
    drain("lock");
  endtask

  task automatic test_full();
    logic o;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk); clear_inputs();
      inst_req = 1'b1; inst_addr = 32'h100 + 32'(i); mem_addr_ok = 1'b1; #1;
      total++; if (inst_addr_ok !== 1'b1) begin bad++; $display("FAIL full fill%0d inst_addr_ok: got %b want 1", i, inst_addr_ok); end
      exp_q.push_back(1'b0);
    end
    @(negedge clk); #1;
    total++; if (mem_req !== 1'b0 || inst_addr_ok !== 1'b0) begin bad++; $display("FAIL full blocked req/ok: got %b%b want 00", mem_req, inst_addr_ok); end
    total++; if (outstanding !== 3'd4) begin bad++; $display("FAIL full outstanding: got %0d want 4", outstanding); end
    @(negedge clk); mem_data_ok = 1'b1; mem_rdata = 32'h5A5A_0001; #1;
    o = exp_q.pop_front();
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL full pop-cycle mem_req: got %b want 0", mem_req); end
    total++; if (inst_data_ok !== ~o || data_data_ok !== o) begin bad++; $display("FAIL full pop data_ok {i,d}: got %b%b want %b%b", inst_data_ok, data_data_ok, ~o, o); end
    @(negedge clk); mem_data_ok = 1'b0; #1;
    total++; if (mem_req !== 1'b1 || inst_addr_ok !== 1'b1) begin bad++; $display("FAIL full reassert req/ok: got %b%b want 11", mem_req, inst_addr_ok); end
    total++; if (outstanding !== 3'd3) begin bad++; $display("FAIL full after pop outstanding: got %0d want 3", outstanding); end
    exp_q.push_back(1'b0);
    drain("full");
  endtask

  task automatic test_wrap();
    logic [9:0] pat;
    logic       o;
    logic       w;
    pat = 10'b1011001101;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); clear_inputs();
      w = pat[i];
      data_req = w; inst_req = ~w;
      data_addr = 32'h200 + 32'(i); inst_addr = 32'h300 + 32'(i);
      mem_addr_ok = 1'b1; mem_data_ok = (i >= 2); mem_rdata = 32'hA000_0000 + 32'(i); #1;
      total++; if ({data_addr_ok, inst_addr_ok} !== {w, ~w}) begin bad++; $display("FAIL wrap%0d addr_ok {d,i}: got %b%b want %b%b", i, data_addr_ok, inst_addr_ok, w, ~w); end
      if (i >= 2) begin
        o = exp_q.pop_front();
        total++; if (outstanding !== 3'd2) begin bad++; $display("FAIL wrap%0d outstanding: got %0d want 2", i, outstanding); end
        total++; if ({data_data_ok, inst_data_ok} !== {o, ~o}) begin bad++; $display("FAIL wrap%0d data_ok {d,i}: got %b%b want %b%b", i, data_data_ok, inst_data_ok, o, ~o); end
      end
      exp_q.push_back(w);
    end
    drain("wrap");
  endtask

  task automatic test_resp_err();
    @(negedge clk); clear_inputs(); mem_data_ok = 1'b1; #1;
    total++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin bad++; $display("FAIL err stray data_ok: got %b want 00", {inst_data_ok, data_data_ok}); end
    @(negedge clk); clear_inputs(); #1;
    total++; if (resp_err !== 1'b1) begin bad++; $display("FAIL err set: got %b want 1", resp_err); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); clear_inputs(); inst_req = 1'b1; mem_addr_ok = 1'b1; #1;
      exp_q.push_back(1'b0);
    end
    @(negedge clk); clear_inputs(); #1;
    total++; if (outstanding !== 3'd3) begin bad++; $display("FAIL err outstanding: got %0d want 3", outstanding); end
    total++; if (resp_err !== 1'b1) begin bad++; $display("FAIL err held: got %b want 1", resp_err); end
    reset = 1'b1;
    @(negedge clk); reset = 1'b0; #1;
    exp_q.delete();
    total++; if (outstanding !== 3'd0) begin bad++; $display("FAIL err reset outstanding: got %0d want 0", outstanding); end
    total++; if (resp_err !== 1'b0) begin bad++; $display("FAIL err reset resp_err: got %b want 0", resp_err); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_priority();
    test_lock();
    test_full();
    test_wrap();
    test_resp_err();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_req_arbiter.md
# sram_req_arbiter

Arbiter that shares one SRAM-like memory port (req/addr_ok/data_ok protocol) between the instruction-fetch requester (M0) and the load/store requester (M1). It sits between the pipeline's inst/data SRAM-like interfaces and the single downstream bridge port. It grants address phases by fixed priority with grant locking, records the owner of every accepted request in an in-order FIFO, and steers each data_ok/rdata beat back to its owner.

## Interface
- DEPTH, 4, max outstanding accepted requests; power of two, 2..16
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- inst_req  in  1  M0 request (read only)
- inst_size  in  2  M0 size (0:1B, 1:2B, 2:4B)
- inst_addr  in  32  M0 address
- inst_addr_ok  out  1  M0 address accepted
- inst_data_ok  out  1  M0 read data valid
- inst_rdata  out  32  M0 read data, equals mem_rdata
- data_req  in  1  M1 request
- data_wr  in  1  M1 write=1 / read=0
- data_size  in  2  M1 size
- data_wstrb  in  4  M1 write strobes
- data_addr  in  32  M1 address
- data_wdata  in  32  M1 write data
- data_addr_ok  out  1  M1 address accepted
- data_data_ok  out  1  M1 read data returned / write completed
- data_rdata  out  32  M1 read data, equals mem_rdata
- mem_req  out  1  downstream request
- mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata  out  1/2/4/32/32  granted master's fields; M0 grant forces wr=0, wstrb=0, wdata=0
- mem_addr_ok  in  1  downstream address accepted
- mem_data_ok  in  1  downstream response beat
- mem_rdata  in  32  downstream read data
- outstanding  out  $clog2(DEPTH)+1  accepted-but-unanswered count
- resp_err  out  1  sticky: mem_data_ok received with FIFO empty

## Operation
- Grant FSM, states IDLE, LOCK_I, LOCK_D; reset to IDLE.
- IDLE: grant data if data_req, else inst if inst_req (M1 priority). If the granted request has no mem_addr_ok this cycle: IDLE->LOCK_D / LOCK_I. If handshake occurs: stay IDLE.
- LOCK_x: grant held to x regardless of the other req; mem_* fields come from x. On handshake (mem_req & mem_addr_ok): ->IDLE. If x drops req without handshake: ->IDLE, no push.
- mem_req = granted master's req & ~full. x_addr_ok = grant==x & mem_req & mem_addr_ok; never to a non-granted master.
- Handshake pushes owner bit (0=M0, 1=M1) into owner FIFO (DEPTH entries, wrap-around rd/wr pointers, count register).
- mem_data_ok pops head; inst_data_ok = mem_data_ok & head==0 & ~empty; data_data_ok = mem_data_ok & head==1 & ~empty.
- mem_data_ok with empty FIFO: no pop, no data_ok to either master, resp_err set until reset.
- full (count==DEPTH) blocks mem_req even if a pop occurs the same cycle (no data_ok→req path).
- Push and pop in the same cycle: both pointers advance, count unchanged.

## Timing
- Reset values: mem_req 0, all *_addr_ok/*_data_ok 0, outstanding 0, resp_err 0, FSM IDLE, pointers 0.
- addr_ok and data_ok are combinational pass-throughs: zero added latency on both phases.
- The pop on a response is visible in outstanding the following cycle; the freed slot is usable on the next cycle.
- Responses are strictly in acceptance order; the block never reorders.
- Reset mid-transaction discards all FIFO entries; the downstream is reset together.

## Test plan
- Single M0 read at 0x1C000000, mem_addr_ok same cycle, data_ok 2 cycles later -> inst_addr_ok at cycle 0, inst_data_ok with rdata, data_data_ok stays 0, outstanding 1 then 0.
- inst_req and data_req (read 0x1000) asserted together, mem_addr_ok=1 -> M1 accepted first, M0 next cycle; responses A,B -> data_data_ok on A, inst_data_ok on B.
- M0 granted, mem_addr_ok held 0 for 3 cycles, data_req rises in cycle 1 -> FSM LOCK_I; mem_addr stays M0's; M1 granted only after M0's handshake.
- DEPTH=4: 4 M0 handshakes with no responses -> mem_req 0 on 5th request while full; on a data_ok pop, mem_req reasserts the next cycle.
- Same-cycle push and pop at count 2 -> outstanding stays 2, owner order preserved across pointer wrap (drive 10 requests).
- mem_data_ok with FIFO empty -> no data_ok out, resp_err 1 and held until reset; reset with 3 outstanding -> outstanding 0 next cycle.
